// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl_pkg : state encodings and default rates for run control  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu_run_ctrl_pkg;

  localparam int STATE_W = 2;

  // Encoding is also decoded by the 7-segment display mux.
  typedef enum logic [STATE_W-1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int          TICK_DIV_DEF  = 20_000_000;
  localparam int          DEBOUNCE_DEF  = 1_000_000;
  localparam logic [31:0] CYCLE_CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic is_halted(input run_state_t s);
    return (s == ST_PAUSE) || (s == ST_BREAK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl_if : board/core controls and status of the run control   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface cpu_run_ctrl_if #(
  parameter int PC_W = 32
);
  import cpu_run_ctrl_pkg::*;

  logic               run_sw;
  logic               step_btn;
  logic               stop;
  logic               bp_en;
  logic [PC_W-1:0]    bp_addr;
  logic [PC_W-1:0]    pc;
  logic               cpu_ce;
  logic               halted;
  logic [STATE_W-1:0] state;
  logic [31:0]        cycle_cnt;

  modport master (
    output run_sw, step_btn, stop, bp_en, bp_addr, pc,
    input  cpu_ce, halted, state, cycle_cnt
  );

  modport slave (
    input  run_sw, step_btn, stop, bp_en, bp_addr, pc,
    output cpu_ce, halted, state, cycle_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl_btn_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl_btn_debounce : 2-flop sync, debounce, press pulse        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu_run_ctrl_btn_debounce #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn,
  output logic      press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  // Any sample agreeing with the accepted level restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], btn};
      r_level_q <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl : clock-enable based run/step/stop/breakpoint controller |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int PC_W     = 32
) (
  input wire logic      clk,
  input wire logic      rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic              w_run;
  logic              w_stop;
  logic              w_bp_en;
  logic              w_step_req;
  run_state_t        r_state;
  run_state_t        w_state_nxt;
  logic              r_cpu_ce;
  logic              w_ce_nxt;
  logic              r_halted;
  logic              r_bp_skip;
  logic              w_bp_skip_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic              w_bp_hit;
  logic [31:0]       r_cycle_cnt;
  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_bp_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {bus.bp_en, bus.stop, bus.run_sw};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_bp_en, w_stop, w_run} = r_sync2;

  cpu_run_ctrl_btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.step_btn),
    .press (w_step_req)
  );

  assign w_pc      = bus.pc;
  assign w_bp_addr = bus.bp_addr;
  assign w_tick    = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);
  assign w_bp_hit  = w_bp_en && (w_pc == w_bp_addr) && !r_bp_skip;

  always_comb begin
    w_state_nxt   = r_state;
    w_ce_nxt      = 1'b0;
    w_bp_skip_nxt = r_bp_skip;
    case (r_state)
      ST_PAUSE: begin
        if (!w_stop) begin
          if (w_step_req)  w_state_nxt = ST_STEP;
          else if (w_run)  w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Exits take priority, so a tick in the exit cycle never reaches the core.
        if (w_stop || !w_run)  w_state_nxt = ST_PAUSE;
        else if (w_bp_hit)     w_state_nxt = ST_BREAK;
        else                   w_ce_nxt    = w_tick;
      end
      ST_STEP: w_state_nxt = ST_PAUSE;
      ST_BREAK: begin
        if (w_step_req)                       w_state_nxt = ST_STEP;
        else if (!w_run || w_stop || !w_bp_en) w_state_nxt = ST_PAUSE;
      end
      default: w_state_nxt = ST_PAUSE;
    endcase
    if (w_state_nxt == ST_STEP) w_ce_nxt = 1'b1;
    // Leaving BREAK arms the skip so execution can move past the breakpoint PC.
    if ((r_state == ST_BREAK) && (w_state_nxt != ST_BREAK)) w_bp_skip_nxt = 1'b1;
    else if (w_pc != w_bp_addr)                             w_bp_skip_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_PAUSE;
      r_halted    <= 1'b1;
      r_cpu_ce    <= 1'b0;
      r_bp_skip   <= 1'b0;
      r_tick_cnt  <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_halted  <= is_halted(w_state_nxt);
      r_cpu_ce  <= w_ce_nxt;
      r_bp_skip <= w_bp_skip_nxt;
      if (r_state == ST_RUN) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      else                   r_tick_cnt <= '0;
      if (r_cpu_ce && (r_cycle_cnt != CYCLE_CNT_MAX)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign bus.cpu_ce    = r_cpu_ce;
  assign bus.halted    = r_halted;
  assign bus.state     = r_state;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire
